// File: rtl/sprite_rom_arbiter.sv
// Sprite ROM arbiter: shares one single-port ROM among NREQ requesters on the pixel clock.
// Strict priority for requester 0 during active video, round-robin otherwise, tagged fixed-latency return.
module sprite_rom_arbiter #(
    parameter int NREQ    = 3,
    parameter int ADDR_W  = 15,
    parameter int DATA_W  = 4,
    parameter int ROM_LAT = 2
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   active,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*ADDR_W-1:0] addr,
    output logic [NREQ-1:0]        gnt,
    output logic [ADDR_W-1:0]      rom_addr,
    output logic                   rom_rd,
    input  logic [DATA_W-1:0]      rom_q,
    output logic [DATA_W-1:0]      rdata,
    output logic [NREQ-1:0]        rvalid
);
    localparam int IDX_W = $clog2(NREQ);

    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  ptr_nxt;
    logic [NREQ-1:0]   elig;
    logic [IDX_W-1:0]  cand;
    logic [IDX_W-1:0]  win;
    logic              hit;
    logic [ADDR_W-1:0] win_addr;
    logic [IDX_W-1:0]  tag_p [ROM_LAT+1];
    logic [ROM_LAT:0]  vld_p;

    // Requester 0 pre-empts everyone in active video; otherwise search from ptr.
    always_comb begin
        elig = req;
        if (active) begin
            if (req[0]) begin
                elig = NREQ'(1);
            end else begin
                elig[0] = 1'b0;
            end
        end
        hit  = 1'b0;
        win  = '0;
        cand = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IDX_W'((int'(ptr) + k) % NREQ);
            if (!hit && !Reset && elig[cand]) begin
                hit = 1'b1;
                win = cand;
            end
        end
    end

    always_comb begin
        gnt      = '0;
        win_addr = '0;
        for (int i = 0; i < NREQ; i++) begin
            gnt[i] = hit && (win == IDX_W'(i));
            if (win == IDX_W'(i)) begin
                win_addr = addr[i*ADDR_W +: ADDR_W];
            end
        end
        ptr_nxt = (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
    end

    // Stage p0: ROM address/strobe register and tag entry; p1..pROM_LAT track the ROM latency.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ptr      <= '0;
            rom_rd   <= 1'b0;
            rom_addr <= '0;
            vld_p    <= '0;
            rdata    <= '0;
            rvalid   <= '0;
        end else begin
            rom_rd <= hit;
            if (hit) begin
                rom_addr <= win_addr;
                ptr      <= ptr_nxt;
            end
            vld_p <= {vld_p[ROM_LAT-1:0], hit};
            // Return stage: ROM word lands while the tag sits at the pipeline end.
            if (vld_p[ROM_LAT]) begin
                rdata <= rom_q;
            end
            for (int i = 0; i < NREQ; i++) begin
                rvalid[i] <= vld_p[ROM_LAT] && (tag_p[ROM_LAT] == IDX_W'(i));
            end
        end
    end

    // Tag indices are qualified by vld_p, so they need no reset.
    always_ff @(posedge Clk) begin
        tag_p[0] <= win;
        for (int i = 1; i <= ROM_LAT; i++) begin
            tag_p[i] <= tag_p[i-1];
        end
    end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Scoreboard bench for sprite_rom_arbiter: directed grant vectors push expected ROM
// accesses and returns; a negedge monitor pops and compares them.
module tb_sprite_rom_arbiter;
    localparam int NREQ    = 3;
    localparam int ADDR_W  = 15;
    localparam int DATA_W  = 4;
    localparam int ROM_LAT = 2;

    localparam logic [ADDR_W-1:0] A0 = 15'h0101;
    localparam logic [ADDR_W-1:0] A1 = 15'h0A12;
    localparam logic [ADDR_W-1:0] A2 = 15'h1234;
    localparam logic [ADDR_W-1:0] B0 = 15'h2A07;
    localparam logic [ADDR_W-1:0] B1 = 15'h0F0B;
    localparam logic [ADDR_W-1:0] B2 = 15'h7FFF;
    localparam logic [ADDR_W-1:0] Z  = 15'h0000;

    logic                   Clk    = 1'b0;
    logic                   Reset  = 1'b1;
    logic                   active = 1'b0;
    logic [NREQ-1:0]        req    = '0;
    logic [NREQ*ADDR_W-1:0] addr   = '0;
    logic [NREQ-1:0]        gnt;
    logic [ADDR_W-1:0]      rom_addr;
    logic                   rom_rd;
    logic [DATA_W-1:0]      rom_q  = '0;
    logic [DATA_W-1:0]      rom_s1 = '0;
    logic [DATA_W-1:0]      rdata;
    logic [NREQ-1:0]        rvalid;

    int cyc       = 0;
    int total_cnt = 0;
    int pass_cnt  = 0;

    typedef struct {
        int               due;
        logic [ADDR_W-1:0] a;
    } rom_t;

    typedef struct {
        int               due;
        logic [NREQ-1:0]  v;
        logic [DATA_W-1:0] d;
    } ret_t;

    rom_t rom_exp[$];
    ret_t ret_exp[$];

    logic [ADDR_W-1:0] last_rom_addr = '0;
    logic [DATA_W-1:0] last_rdata    = '0;
    rom_t              rom_e;
    ret_t              ret_e;

    sprite_rom_arbiter #(
        .NREQ    (NREQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .ROM_LAT (ROM_LAT)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .active   (active),
        .req      (req),
        .addr     (addr),
        .gnt      (gnt),
        .rom_addr (rom_addr),
        .rom_rd   (rom_rd),
        .rom_q    (rom_q),
        .rdata    (rdata),
        .rvalid   (rvalid)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    // Two-cycle registered ROM whose word is the low nibble of its address.
    always @(posedge Clk) begin
        rom_s1 <= rom_addr[DATA_W-1:0];
        rom_q  <= rom_s1;
    end

    function automatic void chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        total_cnt++;
        if (act_v === exp_v) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, act_v, exp_v);
        end
    endfunction

    task automatic step(input logic rst, input logic act, input logic [NREQ-1:0] rq,
                        input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                        input logic [ADDR_W-1:0] a2, input logic [NREQ-1:0] eg);
        logic [ADDR_W-1:0] ga;
        rom_t rn;
        ret_t tn;
        @(posedge Clk);
        #1;
        Reset  = rst;
        active = act;
        req    = rq;
        addr   = {a2, a1, a0};
        @(negedge Clk);
        chk("gnt", 32'(gnt), 32'(eg));
        if (eg != '0) begin
            ga     = eg[0] ? a0 : (eg[1] ? a1 : a2);
            rn.due = cyc + 1;
            rn.a   = ga;
            tn.due = cyc + 2 + ROM_LAT;
            tn.v   = eg;
            tn.d   = ga[DATA_W-1:0];
            rom_exp.push_back(rn);
            ret_exp.push_back(tn);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b0, 3'b000, Z, Z, Z, 3'b000);
        end
    endtask

    always @(negedge Clk) begin
        if (rom_exp.size() > 0 && rom_exp[0].due == cyc) begin
            rom_e = rom_exp.pop_front();
            chk("rom_rd", 32'(rom_rd), 32'(1));
            chk("rom_addr", 32'(rom_addr), 32'(rom_e.a));
            last_rom_addr = rom_e.a;
        end else begin
            chk("rom_idle", 32'({rom_rd, rom_addr}), 32'({1'b0, last_rom_addr}));
        end
        if (ret_exp.size() > 0 && ret_exp[0].due == cyc) begin
            ret_e = ret_exp.pop_front();
            chk("rvalid", 32'(rvalid), 32'(ret_e.v));
            chk("rdata", 32'(rdata), 32'(ret_e.d));
            last_rdata = ret_e.d;
        end else begin
            chk("ret_idle", 32'({rvalid, rdata}), 32'({3'b000, last_rdata}));
        end
        if (Reset) begin
            while (rom_exp.size() > 0 && rom_exp[$].due > cyc) void'(rom_exp.pop_back());
            while (ret_exp.size() > 0 && ret_exp[$].due > cyc) void'(ret_exp.pop_back());
            last_rom_addr = '0;
            last_rdata    = '0;
        end
    end

    initial begin
        // Reset held with all requesting, then full round-robin rotation.
        step(1'b1, 1'b0, 3'b111, A0, A1, A2, 3'b000);
        step(1'b1, 1'b0, 3'b111, A0, A1, A2, 3'b000);
        step(1'b0, 1'b0, 3'b111, A0, A1, A2, 3'b001);
        step(1'b0, 1'b0, 3'b111, A0, A1, A2, 3'b010);
        step(1'b0, 1'b0, 3'b111, A0, A1, A2, 3'b100);
        step(1'b0, 1'b0, 3'b111, B0, B1, B2, 3'b001);
        step(1'b0, 1'b0, 3'b111, B0, B1, B2, 3'b010);
        step(1'b0, 1'b0, 3'b111, B0, B1, B2, 3'b100);

        // Active video: requester 0 wins every cycle, then ptr=1 serves 1 then 2.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 3'b111, A0, A1, A2, 3'b001);
        step(1'b0, 1'b1, 3'b110, A0, B1, B2, 3'b010);
        step(1'b0, 1'b1, 3'b110, A0, A1, B2, 3'b100);
        idle(1);

        // Lone requester 2 at 0x1234 returns nibble 4.
        step(1'b0, 1'b0, 3'b100, Z, Z, A2, 3'b100);
        idle(5);

        // Lone requester 0 held is granted back-to-back.
        step(1'b0, 1'b0, 3'b001, B0, Z, Z, 3'b001);
        step(1'b0, 1'b0, 3'b001, A0, Z, Z, 3'b001);
        step(1'b0, 1'b0, 3'b001, B0, Z, Z, 3'b001);

        // Three grants leave ptr=1, then Reset discards the in-flight returns and clears ptr.
        step(1'b0, 1'b0, 3'b110, B0, A1, B2, 3'b010);
        step(1'b0, 1'b0, 3'b111, B0, A1, B2, 3'b100);
        step(1'b0, 1'b0, 3'b111, B0, A1, A2, 3'b001);
        step(1'b1, 1'b0, 3'b111, A0, A1, A2, 3'b000);
        idle(6);
        step(1'b0, 1'b0, 3'b111, A0, B1, A2, 3'b001);
        idle(1);

        // Long idle, then requester 1 alone with no extra latency.
        idle(10);
        step(1'b0, 1'b0, 3'b010, Z, B1, Z, 3'b010);

        // Active toggles between grants; in-flight returns are unaffected.
        step(1'b0, 1'b1, 3'b111, A0, A1, B2, 3'b001);
        step(1'b0, 1'b0, 3'b110, A0, A1, B2, 3'b010);
        step(1'b0, 1'b0, 3'b100, A0, A1, B2, 3'b100);

        idle(8);
        chk("drain", 32'(rom_exp.size() + ret_exp.size()), 32'(0));
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
